// File: rtl/scr1_bpu_pkg.sv
// Shared types for the SCR1 set-associative branch target buffer.
//  btb_entry_t : one BTB way as seen by the lookup/update datapath. Field
//                widths are upper bounds; the module zero-extends its own
//                parameter-sized storage into them.
//  bpu_fsm_e   : control state of the flush engine.
package scr1_bpu_pkg;

  localparam int BTB_TAG_MAX = 32;
  localparam int BTB_TGT_MAX = 64;
  localparam int BTB_CNT_MAX = 8;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [BTB_TGT_MAX-1:0] target;
    logic                   rvi;
    logic [BTB_CNT_MAX-1:0] cnt;
  } btb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bpu_fsm_e;

endpackage

// File: rtl/scr1_bpu_plru.sv
// Tree pseudo-LRU helper for one BTB set (combinational).
//  tree      in  WAYS-1        tree bits; node n has children 2n+1 (left) and
//                              2n+2 (right); a bit of 1 points the victim right
//  victim    out log2(WAYS)    way the tree currently points at
//  touch_way in  log2(WAYS)    way being used
//  tree_next out WAYS-1        tree bits after steering every node on the
//                              path away from touch_way
module scr1_bpu_plru
  import scr1_bpu_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic [WAYS-2:0]         tree,
  output logic [$clog2(WAYS)-1:0] victim,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [WAYS-2:0]         tree_next
);

  localparam int LVL = $clog2(WAYS);

  // Walk from the root; leaves are numbered WAYS-1 .. 2*WAYS-2.
  always_comb begin
    int vnode;
    vnode = 0;
    for (int l = 0; l < LVL; l++) begin
      vnode = 2 * vnode + 1 + int'(tree[vnode[LVL-1:0]]);
    end
    victim = LVL'(vnode - (WAYS - 1));
  end

  // Walk up from the touched leaf; an odd node is a left child, so its
  // parent must point right (1) to steer the victim away from it.
  always_comb begin
    int tnode;
    int tparent;
    tree_next = tree;
    tnode     = int'(touch_way) + WAYS - 1;
    for (int l = 0; l < LVL; l++) begin
      tparent = (tnode - 1) / 2;
      tree_next[tparent[LVL-1:0]] = tnode[0];
      tnode = tparent;
    end
  end

endmodule

// File: rtl/scr1_bpu_sa.sv
// Set-associative branch target buffer with saturating counters for the SCR1 IFU.
//  clk, rst                async active-high reset of control and outputs
//  lkp_req_i, lkp_pc_i     lookup of one fetch word; result one cycle later,
//                          held until the next accepted lookup
//  lkp_hit_o/taken_o/rvi_o per-lane hit, prediction and 32-bit flag
//  lkp_target_o            per-lane target, lane l at [l*XLEN +: XLEN]
//  upd_*                   resolved-branch training
//  flush_req_i             start invalidating the whole BTB (SETS cycles)
//  flush_busy_o            flush in progress
module scr1_bpu_sa
  import scr1_bpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SETS  = 32,
  parameter int WAYS  = 2,
  parameter int CNT_W = 2,
  parameter int TAG_W = 20,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lkp_req_i,
  input  logic [XLEN-1:0]       lkp_pc_i,
  output logic [LANES-1:0]      lkp_hit_o,
  output logic [LANES-1:0]      lkp_taken_o,
  output logic [LANES*XLEN-1:0] lkp_target_o,
  output logic [LANES-1:0]      lkp_rvi_o,
  input  logic                  upd_valid_i,
  input  logic [XLEN-1:0]       upd_pc_i,
  input  logic [XLEN-1:0]       upd_target_i,
  input  logic                  upd_taken_i,
  input  logic                  upd_rvi_i,
  input  logic                  flush_req_i,
  output logic                  flush_busy_o
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int TAG_LSB = 2 + IDX_W;
  localparam logic [CNT_W-1:0] CNT_WT = CNT_W'(1 << (CNT_W - 1));

  function automatic logic [CNT_W-1:0] cnt_sat(input logic [CNT_W-1:0] c, input logic up);
    if (up) return (&c) ? c : c + CNT_W'(1);
    else    return (~|c) ? c : c - CNT_W'(1);
  endfunction

  // Valid and PLRU carry reset; payload arrays do not.
  logic [WAYS-1:0]  valid_q  [LANES][SETS];
  logic [WAYS-2:0]  plru_q   [LANES][SETS];
  logic [TAG_W-1:0] tag_q    [LANES][SETS][WAYS];
  logic [XLEN-1:0]  target_q [LANES][SETS][WAYS];
  logic             rvi_q    [LANES][SETS][WAYS];
  logic [CNT_W-1:0] cnt_q    [LANES][SETS][WAYS];

  bpu_fsm_e         state_q, state_d;
  logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             busy_q;

  // ---- lookup stage p0: tag compare on current storage ----
  logic [IDX_W-1:0] lkp_set;
  logic [TAG_W-1:0] lkp_tag;
  btb_entry_t       lkp_ent_p0 [LANES];

  assign lkp_set = lkp_pc_i[2 +: IDX_W];
  assign lkp_tag = lkp_pc_i[TAG_LSB +: TAG_W];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lkp_ent_p0[l] = '0;
      // Descending scan so the lowest matching way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (valid_q[l][lkp_set][w] && tag_q[l][lkp_set][w] == lkp_tag) begin
          lkp_ent_p0[l].valid  = 1'b1;
          lkp_ent_p0[l].tag    = BTB_TAG_MAX'(tag_q[l][lkp_set][w]);
          lkp_ent_p0[l].target = BTB_TGT_MAX'(target_q[l][lkp_set][w]);
          lkp_ent_p0[l].rvi    = rvi_q[l][lkp_set][w];
          lkp_ent_p0[l].cnt    = BTB_CNT_MAX'(cnt_q[l][lkp_set][w]);
        end
      end
    end
  end

  // ---- lookup stage p1: registered outputs ----
  logic [LANES-1:0]      hit_p1, taken_p1, rvi_p1;
  logic [LANES*XLEN-1:0] target_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_p1    <= '0;
      taken_p1  <= '0;
      rvi_p1    <= '0;
      target_p1 <= '0;
    end else if (lkp_req_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (state_q == FLUSH) begin
          hit_p1[l]                  <= 1'b0;
          taken_p1[l]                <= 1'b0;
          rvi_p1[l]                  <= 1'b0;
          target_p1[l*XLEN +: XLEN]  <= '0;
        end else begin
          hit_p1[l]                  <= lkp_ent_p0[l].valid;
          taken_p1[l]                <= lkp_ent_p0[l].valid & lkp_ent_p0[l].cnt[CNT_W-1];
          rvi_p1[l]                  <= lkp_ent_p0[l].rvi;
          target_p1[l*XLEN +: XLEN]  <= lkp_ent_p0[l].target[XLEN-1:0];
        end
      end
    end
  end

  assign lkp_hit_o    = hit_p1;
  assign lkp_taken_o  = taken_p1;
  assign lkp_rvi_o    = rvi_p1;
  assign lkp_target_o = target_p1;

  // ---- update: way selection ----
  logic [IDX_W-1:0] upd_set;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_lane;
  logic             upd_en, upd_hit, upd_has_free, upd_write;
  logic [WAY_W-1:0] upd_hit_way, upd_free_way, upd_way;
  logic [WAYS-2:0]  plru_tree   [LANES];
  logic [WAYS-2:0]  plru_next   [LANES];
  logic [WAY_W-1:0] plru_victim [LANES];

  assign upd_set  = upd_pc_i[2 +: IDX_W];
  assign upd_tag  = upd_pc_i[TAG_LSB +: TAG_W];
  assign upd_lane = (LANES > 1) ? upd_pc_i[1] : 1'b0;
  assign upd_en   = upd_valid_i && (state_q == IDLE);

  always_comb begin
    upd_hit      = 1'b0;
    upd_hit_way  = '0;
    upd_has_free = 1'b0;
    upd_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[upd_lane][upd_set][w] && tag_q[upd_lane][upd_set][w] == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!valid_q[upd_lane][upd_set][w]) begin
        upd_has_free = 1'b1;
        upd_free_way = WAY_W'(w);
      end
    end
  end

  assign upd_way   = upd_hit      ? upd_hit_way  :
                     upd_has_free ? upd_free_way : plru_victim[upd_lane];
  assign upd_write = upd_en && (upd_hit || upd_taken_i);

  for (genvar gl = 0; gl < LANES; gl++) begin : g_plru
    assign plru_tree[gl] = plru_q[gl][upd_set];
    scr1_bpu_plru #(.WAYS(WAYS)) u_plru (
      .tree      (plru_tree[gl]),
      .victim    (plru_victim[gl]),
      .touch_way (upd_way),
      .tree_next (plru_next[gl])
    );
  end

  // ---- update: state write ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[l][s] <= '0;
          plru_q[l][s]  <= '0;
        end
      end
    end else if (state_q == FLUSH) begin
      for (int l = 0; l < LANES; l++) begin
        valid_q[l][flush_cnt_q] <= '0;
        plru_q[l][flush_cnt_q]  <= '0;
      end
    end else if (upd_write) begin
      valid_q[upd_lane][upd_set][upd_way] <= 1'b1;
      plru_q[upd_lane][upd_set]           <= plru_next[upd_lane];
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (upd_hit) begin
        cnt_q[upd_lane][upd_set][upd_way] <= cnt_sat(cnt_q[upd_lane][upd_set][upd_way], upd_taken_i);
        if (upd_taken_i) begin
          target_q[upd_lane][upd_set][upd_way] <= upd_target_i;
          rvi_q[upd_lane][upd_set][upd_way]    <= upd_rvi_i;
        end
      end else if (upd_taken_i) begin
        tag_q[upd_lane][upd_set][upd_way]    <= upd_tag;
        target_q[upd_lane][upd_set][upd_way] <= upd_target_i;
        rvi_q[upd_lane][upd_set][upd_way]    <= upd_rvi_i;
        cnt_q[upd_lane][upd_set][upd_way]    <= CNT_WT;
      end
    end
  end

  // ---- flush engine ----
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= (state_d == FLUSH);
    end
  end

  assign flush_busy_o = busy_q;

endmodule

// File: tb/tb_scr1_bpu_sa.sv
module tb_scr1_bpu_sa;

  logic        clk = 1'b0;
  logic        rst;
  logic        lkp_req_i;
  logic [31:0] lkp_pc_i;
  logic [1:0]  lkp_hit_o, lkp_taken_o, lkp_rvi_o;
  logic [63:0] lkp_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i, upd_target_i;
  logic        upd_taken_i, upd_rvi_i;
  logic        flush_req_i;
  logic        flush_busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  scr1_bpu_sa #(.XLEN(32), .SETS(32), .WAYS(2), .CNT_W(2), .TAG_W(20), .LANES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .lkp_req_i    (lkp_req_i),
    .lkp_pc_i     (lkp_pc_i),
    .lkp_hit_o    (lkp_hit_o),
    .lkp_taken_o  (lkp_taken_o),
    .lkp_target_o (lkp_target_o),
    .lkp_rvi_o    (lkp_rvi_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i),
    .upd_rvi_i    (upd_rvi_i),
    .flush_req_i  (flush_req_i),
    .flush_busy_o (flush_busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [69:0] lkp_pack(input logic [1:0] h, input logic [1:0] t,
                                           input logic [31:0] t0, input logic [31:0] t1,
                                           input logic [1:0] r);
    return {h, t, t1, t0, r};
  endfunction

  function automatic logic [69:0] dut_pack();
    return {lkp_hit_o, lkp_taken_o, lkp_target_o, lkp_rvi_o};
  endfunction

  task automatic idle_inputs();
    lkp_req_i = 0; lkp_pc_i = 0; upd_valid_i = 0; upd_pc_i = 0;
    upd_target_i = 0; upd_taken_i = 0; upd_rvi_i = 0; flush_req_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic lkp_check(input string name, input logic [31:0] pc, input logic [69:0] exp);
    @(negedge clk);
    lkp_req_i = 1; lkp_pc_i = pc;
    @(posedge clk); #1;
    lkp_req_i = 0;
    check(name, 128'(dut_pack()), 128'(exp));
  endtask

  task automatic upd_once(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic rv);
    @(negedge clk);
    upd_valid_i = 1; upd_pc_i = pc; upd_target_i = tgt; upd_taken_i = tk; upd_rvi_i = rv;
    @(posedge clk); #1;
    upd_valid_i = 0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ut;
    logic        ur;
    logic        lv;
    logic [31:0] lpc;
    logic [1:0]  hit;
    logic [1:0]  tkn;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [1:0]  rvi;
  } vec_t;

  vec_t vq[$];

  task automatic fill_vectors();
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h200,  2'b00, 2'b00, 32'h0,    32'h0,    2'b00});
    vq.push_back('{1'b1, 32'h1008,   32'h2000,   1'b1, 1'b1, 1'b0, 32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    2'b00});
    vq.push_back('{1'b1, 32'h100A,   32'h3000,   1'b1, 1'b0, 1'b1, 32'h1008, 2'b01, 2'b01, 32'h2000, 32'h0,    2'b01});
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2000, 32'h3000, 2'b01});
    vq.push_back('{1'b1, 32'h1008,   32'hDEAD,   1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2000, 32'h3000, 2'b01});
    vq.push_back('{1'b1, 32'h1008,   32'hDEAD,   1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b10, 32'h2000, 32'h3000, 2'b01});
    vq.push_back('{1'b1, 32'h1008,   32'hDEAD,   1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b10, 32'h2000, 32'h3000, 2'b01});
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b10, 32'h2000, 32'h3000, 2'b01});
    vq.push_back('{1'b1, 32'h1008,   32'h2400,   1'b1, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b10, 32'h2000, 32'h3000, 2'b01});
    vq.push_back('{1'b1, 32'h1008,   32'h2400,   1'b1, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b10, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b1, 32'h1008,   32'h2400,   1'b1, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b1, 32'h1008,   32'h2400,   1'b1, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b1, 32'h1008,   32'h0,      1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b1, 32'h1008,   32'h0,      1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b10, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b1, 32'h2008,   32'h5000,   1'b1, 1'b1, 1'b0, 32'h0,    2'b11, 2'b10, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b1, 32'h1008,   32'h2400,   1'b1, 1'b0, 1'b1, 32'h2008, 2'b01, 2'b01, 32'h5000, 32'h0,    2'b01});
    vq.push_back('{1'b1, 32'h3008,   32'h6000,   1'b1, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2400, 32'h3000, 2'b00});
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h2008, 2'b00, 2'b00, 32'h0,    32'h0,    2'b00});
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h3008, 2'b01, 2'b01, 32'h6000, 32'h0,    2'b00});
    vq.push_back('{1'b0, 32'h0,      32'h0,      1'b0, 1'b0, 1'b1, 32'h1008, 2'b11, 2'b11, 32'h2400, 32'h3000, 2'b00});
  endtask

  // ---------------- behavioural reference model ----------------
  // Each (lane,set) holds two ways; with two ways tree-PLRU is plain LRU,
  // so the model remembers which way was used least recently.
  bit          m_valid [2][32][2];
  int          m_tag   [2][32][2];
  logic [31:0] m_tgt   [2][32][2];
  bit          m_rvi   [2][32][2];
  int          m_cnt   [2][32][2];
  int          m_lru   [2][32];
  logic [69:0] m_out;

  task automatic m_reset();
    for (int l = 0; l < 2; l++)
      for (int s = 0; s < 32; s++) begin
        m_lru[l][s] = 0;
        for (int w = 0; w < 2; w++) m_valid[l][s][w] = 0;
      end
    m_out = '0;
  endtask

  function automatic int m_find(input int l, input int s, input int t);
    for (int w = 0; w < 2; w++)
      if (m_valid[l][s][w] && m_tag[l][s][w] == t) return w;
    return -1;
  endfunction

  task automatic m_lookup(input logic [31:0] pc);
    int s, t, w;
    logic [1:0] h, tk, r;
    logic [31:0] tg [2];
    s = int'(pc[6:2]); t = int'(pc[26:7]);
    for (int l = 0; l < 2; l++) begin
      w = m_find(l, s, t);
      h[l] = (w >= 0);
      tk[l] = (w >= 0) && (m_cnt[l][s][w] >= 2);
      r[l] = (w >= 0) ? m_rvi[l][s][w] : 1'b0;
      tg[l] = (w >= 0) ? m_tgt[l][s][w] : 32'h0;
    end
    m_out = lkp_pack(h, tk, tg[0], tg[1], r);
  endtask

  task automatic m_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit rv);
    int l, s, t, w;
    l = int'(pc[1]); s = int'(pc[6:2]); t = int'(pc[26:7]);
    w = m_find(l, s, t);
    if (w >= 0) begin
      m_cnt[l][s][w] = tk ? ((m_cnt[l][s][w] == 3) ? 3 : m_cnt[l][s][w] + 1)
                          : ((m_cnt[l][s][w] == 0) ? 0 : m_cnt[l][s][w] - 1);
      if (tk) begin m_tgt[l][s][w] = tgt; m_rvi[l][s][w] = rv; end
      m_lru[l][s] = 1 - w;
    end else if (tk) begin
      if (!m_valid[l][s][0]) w = 0;
      else if (!m_valid[l][s][1]) w = 1;
      else w = m_lru[l][s];
      m_valid[l][s][w] = 1; m_tag[l][s][w] = t; m_tgt[l][s][w] = tgt;
      m_rvi[l][s][w] = rv; m_cnt[l][s][w] = 2;
      m_lru[l][s] = 1 - w;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int busy_cycles;
    logic [31:0] rpc, rlpc, rtgt;
    bit ruv, rlv, rtk, rrv;

    do_reset();
    check("reset_outputs", 128'(dut_pack()), 128'(0));
    check("reset_busy", 128'(flush_busy_o), 128'(0));

    fill_vectors();
    foreach (vq[i]) begin
      @(negedge clk);
      upd_valid_i = vq[i].uv; upd_pc_i = vq[i].upc; upd_target_i = vq[i].utgt;
      upd_taken_i = vq[i].ut; upd_rvi_i = vq[i].ur;
      lkp_req_i = vq[i].lv; lkp_pc_i = vq[i].lpc;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 128'(dut_pack()),
            128'(lkp_pack(vq[i].hit, vq[i].tkn, vq[i].t0, vq[i].t1, vq[i].rvi)));
    end
    idle_inputs();

    // Flush with a same-edge update, then mid-flush update/lookup/re-request.
    @(negedge clk);
    flush_req_i = 1; upd_valid_i = 1; upd_pc_i = 32'h4008; upd_target_i = 32'h7000;
    upd_taken_i = 1; upd_rvi_i = 1;
    @(posedge clk); #1;
    idle_inputs();
    busy_cycles = 0;
    while (flush_busy_o && busy_cycles < 200) begin
      busy_cycles++;
      if (busy_cycles == 5) begin
        flush_req_i = 1; upd_valid_i = 1; upd_pc_i = 32'h5008; upd_target_i = 32'h7700;
        upd_taken_i = 1; lkp_req_i = 1; lkp_pc_i = 32'h1008;
      end
      @(posedge clk); #1;
      if (busy_cycles == 5) begin
        check("lkp_during_flush", 128'(dut_pack()), 128'(0));
        idle_inputs();
      end
    end
    check("flush_busy_cycles", 128'(busy_cycles), 128'(32));
    lkp_check("post_flush_1008", 32'h1008, '0);
    lkp_check("post_flush_3008", 32'h3008, '0);
    lkp_check("post_flush_4008", 32'h4008, '0);
    lkp_check("dropped_upd_5008", 32'h5008, '0);

    // Reset asserted in the middle of a flush.
    upd_once(32'h1050, 32'h8000, 1'b1, 1'b1);
    lkp_check("pre_rst_lkp", 32'h1050, lkp_pack(2'b01, 2'b01, 32'h8000, 32'h0, 2'b01));
    @(negedge clk); flush_req_i = 1;
    @(posedge clk); #1; flush_req_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_rst", 128'(flush_busy_o), 128'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_flush_busy", 128'(flush_busy_o), 128'(0));
    check("rst_mid_flush_outputs", 128'(dut_pack()), 128'(0));
    @(negedge clk); rst = 1'b0;
    lkp_check("valid_cleared_by_rst", 32'h1050, '0);

    // Randomised traffic against the reference model.
    do_reset();
    m_reset();
    for (int c = 0; c < 800; c++) begin
      ruv  = ($urandom_range(0, 1) == 1);
      rtk  = ($urandom_range(0, 2) != 0);
      rrv  = ($urandom_range(0, 1) == 1);
      rtgt = $urandom;
      rpc  = (32'($urandom_range(1, 3)) << 7) | (32'($urandom_range(0, 3)) << 2) |
             (32'($urandom_range(0, 1)) << 1);
      rlv  = ($urandom_range(0, 9) < 7);
      rlpc = (32'($urandom_range(1, 3)) << 7) | (32'($urandom_range(0, 3)) << 2);
      @(negedge clk);
      upd_valid_i = ruv; upd_pc_i = rpc; upd_target_i = rtgt;
      upd_taken_i = rtk; upd_rvi_i = rrv;
      lkp_req_i = rlv; lkp_pc_i = rlpc;
      @(posedge clk); #1;
      if (rlv) m_lookup(rlpc);
      if (ruv) m_update(rpc, rtgt, rtk, rrv);
      check($sformatf("rand%0d", c), 128'(dut_pack()), 128'(m_out));
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
